pipeline_t: RTL

//  Fetch stage directly upstream of the D pipeline register. Owns the fetch PC, runs a
//  req/ack handshake with instruction memory, buffers returned words in a 2-entry
//  (output + skid) queue, and presents t_inst / t_next_inst_pc / dbg_t_pc to D.

---
 rtl/pipeline_t.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/pipeline_t.sv
// ---------------------------------------------------------------------------
// pipeline_t : fetch stage feeding the D pipeline register.
//
// Owns the fetch PC and runs a req/ack handshake with instruction memory.
// Returned words are buffered in a two-entry queue: an output register and a
// skid register behind it. The output register drives t_inst,
// t_next_inst_pc and dbg_t_pc. A branch/jump redirect discards queued
// entries and any in-flight fetch, then refetches from the new target.
//
// Ports
//   clk            in   1   clock, rising edge
//   resetn         in   1   asynchronous active-low reset
//   d_stall        in   1   D cannot accept; output entry held
//   redirect       in   1   one-cycle pulse: flush, refetch at redirect_pc
//   redirect_pc    in   32  redirect target (bits [1:0] ignored)
//   imem_req       out  1   fetch request; address stable while high
//   imem_addr      out  32  fetch byte address
//   imem_ack       in   1   transfer completes when imem_req & imem_ack
//   imem_rdata     in   32  instruction word, valid in the ack cycle
//   t_valid        out  1   outputs hold a real instruction
//   t_inst         out  32  instruction word, 0 (nop) when !t_valid
//   t_next_inst_pc out  32  fetch address + 4, 0 when !t_valid
//   dbg_t_pc       out  32  fetch address, BUBBLE_PC when !t_valid
// ---------------------------------------------------------------------------
module pipeline_t #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] BUBBLE_PC = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        d_stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        t_valid,
    output logic [31:0] t_inst,
    output logic [31:0] t_next_inst_pc,
    output logic [31:0] dbg_t_pc
);

    typedef enum logic {RUN, DRAIN} state_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } entry_t;

    state_t      state, state_nx;
    logic [31:0] pc, pc_nx;
    logic [31:0] pend_addr, pend_nx;
    logic        run_en;
    entry_t      out_q, out_nx, skid_q, skid_nx;
    logic        out_valid, out_valid_nx;
    logic        skid_valid, skid_valid_nx;

    logic        xfer;
    logic        accept;
    logic        consume;
    entry_t      fetched;
    logic [31:0] redir_aligned;

    // run_en keeps imem_req low while reset is asserted and for the first
    // edge afterwards; request/address are functions of registers only.
    assign imem_req  = run_en & ((state == DRAIN) | ~skid_valid);
    assign imem_addr = (state == DRAIN) ? pend_addr : pc;

    assign xfer          = imem_req & imem_ack;
    assign accept        = (state == RUN) & xfer & ~redirect;
    assign consume       = out_valid & ~d_stall;
    assign fetched       = '{inst: imem_rdata, pc: pc};
    assign redir_aligned = {redirect_pc[31:2], 2'b00};

    always_comb begin
        state_nx      = state;
        pc_nx         = pc;
        pend_nx       = pend_addr;
        out_nx        = out_q;
        out_valid_nx  = out_valid;
        skid_nx       = skid_q;
        skid_valid_nx = skid_valid;

        if (redirect) begin
            out_valid_nx  = 1'b0;
            skid_valid_nx = 1'b0;
            pc_nx         = redir_aligned;
            if (state == RUN) begin
                // An unanswered request must still complete; park its
                // address and swallow the response in DRAIN.
                if (imem_req && !imem_ack) begin
                    pend_nx  = pc;
                    state_nx = DRAIN;
                end
            end else if (imem_ack) begin
                state_nx = RUN;
            end
        end else begin
            if (state == DRAIN && xfer)
                state_nx = RUN;

            if (accept)
                pc_nx = pc + 32'd4;

            if (consume) begin
                if (skid_valid) begin
                    // imem_req is low while skid is full, so no accept here.
                    out_nx        = skid_q;
                    skid_valid_nx = 1'b0;
                end else if (accept) begin
                    out_nx = fetched;
                end else begin
                    out_valid_nx = 1'b0;
                end
            end else if (accept) begin
                if (!out_valid) begin
                    out_nx       = fetched;
                    out_valid_nx = 1'b1;
                end else begin
                    skid_nx       = fetched;
                    skid_valid_nx = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= RUN;
            pc         <= RESET_PC;
            pend_addr  <= RESET_PC;
            run_en     <= 1'b0;
            out_q      <= '0;
            out_valid  <= 1'b0;
            skid_q     <= '0;
            skid_valid <= 1'b0;
        end else begin
            state      <= state_nx;
            pc         <= pc_nx;
            pend_addr  <= pend_nx;
            run_en     <= 1'b1;
            out_q      <= out_nx;
            out_valid  <= out_valid_nx;
            skid_q     <= skid_nx;
            skid_valid <= skid_valid_nx;
        end
    end

    assign t_valid        = out_valid;
    assign t_inst         = out_valid ? out_q.inst : 32'h0;
    assign t_next_inst_pc = out_valid ? (out_q.pc + 32'd4) : 32'h0;
    assign dbg_t_pc       = out_valid ? out_q.pc : BUBBLE_PC;

endmodule
